// File: rtl/add_sub_pkg.sv
// Shared types and constants for the add_sub datapath and its two-port arbiter.
package add_sub_pkg;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned RES_W = 5;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/add_sub.sv
// Combinational sign-magnitude adder/subtractor: c = a + b (s=0) or a - b (s=1).
module add_sub
   import add_sub_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic             s,
   output logic [RES_W-1:0] c
);

   logic       sb;
   logic [1:0] ma;
   logic [1:0] mb;

   always_comb begin
      sb = b[2] ^ s;
      ma = a[1:0];
      mb = b[1:0];
      // Equal signs add magnitudes; otherwise the larger magnitude sets the sign.
      if (a[2] == sb) begin
         c = {a[2], {2'b00, ma} + {2'b00, mb}};
      end else if (ma >= mb) begin
         c = {a[2], 2'b00, ma - mb};
      end else begin
         c = {sb, 2'b00, mb - ma};
      end
   end

endmodule

// File: rtl/add_sub_arbiter.sv
// Shares one add_sub datapath between two valid/ready requesters and returns an id-tagged,
// registered result; counts completed response handshakes.
module add_sub_arbiter
   import add_sub_pkg::*;
#(
   parameter bit          ROUND_ROBIN = 1'b1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OP_W-1:0]  req0_a,
   input  logic [OP_W-1:0]  req0_b,
   input  logic             req0_s,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OP_W-1:0]  req1_a,
   input  logic [OP_W-1:0]  req1_b,
   input  logic             req1_s,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [RES_W-1:0] rsp_c,
   output logic             rsp_id,
   output logic             rsp_zero,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_t            state_q, state_d;
   logic              last_grant_q;
   logic [OP_W-1:0]   op_a_q, op_b_q;
   logic              op_s_q, op_id_q;
   logic              grant, accept;
   logic [RES_W-1:0]  c;

   add_sub u_add_sub (
      .a (op_a_q),
      .b (op_b_q),
      .s (op_s_q),
      .c (c)
   );

   always_comb begin
      state_d    = state_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      grant      = PORT0;
      if (req0_valid && req1_valid) begin
         if (ROUND_ROBIN) grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = PORT1;
      end
      unique case (state_q)
         IDLE: begin
            // Ready is gated by rst so nothing is offered while reset is held.
            if (!rst && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               req0_ready = (grant == PORT0);
               req1_ready = (grant == PORT1);
               state_d    = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT1;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_s_q       <= 1'b0;
         op_id_q      <= PORT0;
         rsp_valid    <= 1'b0;
         rsp_c        <= '0;
         rsp_id       <= PORT0;
         rsp_zero     <= 1'b0;
         op_count     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_a_q       <= grant ? req1_a : req0_a;
            op_b_q       <= grant ? req1_b : req0_b;
            op_s_q       <= grant ? req1_s : req0_s;
            op_id_q      <= grant;
            last_grant_q <= grant;
         end
         if (state_q == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id_q;
            rsp_zero  <= (c[3:0] == 4'd0);
            // A zero magnitude is always reported as +0.
            rsp_c     <= (c[3:0] == 4'd0) ? '0 : c;
         end
         if (state_q == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Randomized self-checking bench for add_sub_arbiter: a round-robin and a fixed-priority
// instance checked against an integer-arithmetic reference model.
module tb_add_sub_arbiter;

   logic       clk = 1'b0;
   logic       rst;

   logic       req0_valid, req0_ready, req0_s, req1_valid, req1_ready, req1_s;
   logic [2:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
   logic [4:0] rsp_c;
   logic [7:0] op_count;

   logic       f_req0_valid, f_req0_ready, f_req0_s, f_req1_valid, f_req1_ready, f_req1_s;
   logic [2:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
   logic       f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_zero, f_busy;
   logic [4:0] f_rsp_c;
   logic [7:0] f_op_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit ref_last = 1'b1;
   int exp_count = 0;

   always #5 clk = ~clk;

   add_sub_arbiter #(.ROUND_ROBIN(1'b1), .CNT_W(8)) u_rr (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_s(req0_s),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_s(req1_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_id(rsp_id),
      .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
   );

   add_sub_arbiter #(.ROUND_ROBIN(1'b0), .CNT_W(8)) u_fixed (
      .clk(clk), .rst(rst),
      .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a),
      .req0_b(f_req0_b), .req0_s(f_req0_s),
      .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a),
      .req1_b(f_req1_b), .req1_s(f_req1_s),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_c(f_rsp_c), .rsp_id(f_rsp_id),
      .rsp_zero(f_rsp_zero), .busy(f_busy), .op_count(f_op_count)
   );

   // Signed integer arithmetic on decoded operands; zero always encodes as +0.
   function automatic logic [4:0] ref_c(input logic [2:0] a, input logic [2:0] b,
                                        input logic s);
      int va, vb, r, m;
      va = int'(a[1:0]);
      if (a[2]) va = -va;
      vb = int'(b[1:0]);
      if (b[2]) vb = -vb;
      r = s ? va - vb : va + vb;
      m = (r < 0) ? -r : r;
      if (m == 0) return 5'b00000;
      return {(r < 0) ? 1'b1 : 1'b0, m[3:0]};
   endfunction

   function automatic logic exp_grant(input bit p0, input bit p1);
      if (p0 && p1) return ~ref_last;
      return p1;
   endfunction

   // Drives one request (no checking); called and returns at a falling edge.
   task automatic run_op(input bit p0, input bit p1,
                         input logic [2:0] a0, input logic [2:0] b0, input logic s0,
                         input logic [2:0] a1, input logic [2:0] b1, input logic s1,
                         input int hold,
                         output logic gid, output logic [4:0] c, output logic zero,
                         output logic rid, output int lat, output bit stable, output bit ok);
      logic [7:0] cnt0;
      int waitc;
      ok = 1'b1; stable = 1'b1; gid = 1'b0; c = '0; zero = 1'b0; rid = 1'b0; lat = 0;
      rsp_ready  = (hold == 0);
      req0_valid = p0; req0_a = a0; req0_b = b0; req0_s = s0;
      req1_valid = p1; req1_a = a1; req1_b = b1; req1_s = s1;
      #1;
      waitc = 0;
      while (!(req0_ready || req1_ready) && waitc < 20) begin
         @(negedge clk); #1; waitc++;
      end
      if (!(req0_ready || req1_ready)) begin
         ok = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
         return;
      end
      gid = req1_ready;
      @(negedge clk);
      if (gid) req1_valid = 1'b0;
      else     req0_valid = 1'b0;
      #1;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk); #1; lat++;
      end
      if (!rsp_valid) begin
         ok = 1'b0; rsp_ready = 1'b1;
         return;
      end
      c = rsp_c; zero = rsp_zero; rid = rsp_id; cnt0 = op_count;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_c !== c || rsp_id !== rid || rsp_zero !== zero ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0 || op_count !== cnt0)
            stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; f_req0_valid = 1'b1; f_req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, rsp_c, rsp_id, rsp_zero, busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 000000000",
                  {rsp_valid, rsp_c, rsp_id, rsp_zero, busy});
      end
      n_checks++;
      if (op_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d expected 0", op_count);
      end
      n_checks++;
      if ({req0_ready, req1_ready, f_req0_ready, f_req1_ready} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0000",
                  {req0_ready, req1_ready, f_req0_ready, f_req1_ready});
      end
      req0_valid = 1'b0; req1_valid = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ref_last = 1'b1; exp_count = 0;
      @(negedge clk);
   endtask

   task automatic test_port0();
      logic gid, zero, rid, eg; logic [4:0] c; int lat; bit stable, ok;
      eg = exp_grant(1'b1, 1'b0);
      run_op(1'b1, 1'b0, 3'b011, 3'b010, 1'b0, 3'b000, 3'b000, 1'b0, 0,
             gid, c, zero, rid, lat, stable, ok);
      ref_last = eg; exp_count++;
      #1;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL port0_timeout: got no response expected one"); end
      n_checks++;
      if (c !== 5'b00101) begin n_fail++; $display("FAIL port0_c: got %b expected 00101", c); end
      n_checks++;
      if ({gid, rid, zero} !== {eg, eg, 1'b0}) begin
         n_fail++; $display("FAIL port0_id: got %b expected %b", {gid, rid, zero}, {eg, eg, 1'b0});
      end
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL port0_latency: got %0d expected 2", lat); end
      n_checks++;
      if (op_count !== 8'(exp_count) || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL port0_count: got %0d/%b expected %0d/0", op_count, rsp_valid, exp_count);
      end
   endtask

   task automatic test_port1();
      logic gid, zero, rid, eg; logic [4:0] c; int lat; bit stable, ok;
      logic [2:0] ta [2]; logic [2:0] tb [2]; logic ts [2];
      ta[0] = 3'b111; tb[0] = 3'b001; ts[0] = 1'b0;
      ta[1] = 3'b001; tb[1] = 3'b011; ts[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         eg = exp_grant(1'b0, 1'b1);
         run_op(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, ta[k], tb[k], ts[k], 0,
                gid, c, zero, rid, lat, stable, ok);
         ref_last = eg; exp_count++;
         n_checks++;
         if (!ok || c !== 5'b10010 || c !== ref_c(ta[k], tb[k], ts[k])) begin
            n_fail++; $display("FAIL port1_c%0d: got %b ok=%0d expected 10010", k, c, ok);
         end
         n_checks++;
         if (rid !== 1'b1 || gid !== eg) begin
            n_fail++; $display("FAIL port1_id%0d: got %b/%b expected 1/%b", k, rid, gid, eg);
         end
      end
   endtask

   task automatic test_round_robin();
      logic gid, zero, rid, eg, exp_c; logic [4:0] c, ec; int lat; bit stable, ok;
      logic [2:0] pa [2]; logic [2:0] pb [2]; logic ps [2];
      for (int p = 0; p < 2; p++) begin
         pa[p] = 3'($urandom_range(0, 7)); pb[p] = 3'($urandom_range(0, 7));
         ps[p] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < 4; k++) begin
         eg = exp_grant(1'b1, 1'b1);
         ec = ref_c(pa[eg], pb[eg], ps[eg]);
         run_op(1'b1, 1'b1, pa[0], pb[0], ps[0], pa[1], pb[1], ps[1], 0,
                gid, c, zero, rid, lat, stable, ok);
         ref_last = eg; exp_count++;
         exp_c = (ec[3:0] == 4'd0);
         n_checks++;
         if (!ok || gid !== eg || rid !== eg) begin
            n_fail++; $display("FAIL rr_grant%0d: got %b/%b expected %b", k, gid, rid, eg);
         end
         n_checks++;
         if (c !== ec || zero !== exp_c) begin
            n_fail++; $display("FAIL rr_c%0d: got %b/%b expected %b/%b", k, c, zero, ec, exp_c);
         end
         pa[eg] = 3'($urandom_range(0, 7)); pb[eg] = 3'($urandom_range(0, 7));
         ps[eg] = 1'($urandom_range(0, 1));
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_fixed_priority();
      logic [2:0] a0, b0, a1, b1; logic s0, s1; logic [4:0] ec; int waitc;
      a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7)); s0 = 1'($urandom_range(0, 1));
      a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7)); s1 = 1'($urandom_range(0, 1));
      f_rsp_ready = 1'b1;
      f_req0_a = a0; f_req0_b = b0; f_req0_s = s0; f_req0_valid = 1'b1;
      f_req1_a = a1; f_req1_b = b1; f_req1_s = s1; f_req1_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) f_req0_valid = 1'b0;  // let the pending port through last
         #1;
         waitc = 0;
         while (!(f_req0_ready || f_req1_ready) && waitc < 20) begin
            @(negedge clk); #1; waitc++;
         end
         n_checks++;
         if ({f_req0_ready, f_req1_ready} !== ((k == 4) ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL fixed_grant%0d: got %b expected %b", k, {f_req0_ready, f_req1_ready},
                     (k == 4) ? 2'b01 : 2'b10);
         end
         ec = (k == 4) ? ref_c(a1, b1, s1) : ref_c(a0, b0, s0);
         @(negedge clk);
         if (k < 4) begin
            a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7));
            s0 = 1'($urandom_range(0, 1));
            f_req0_a = a0; f_req0_b = b0; f_req0_s = s0;
         end else begin
            f_req1_valid = 1'b0;
         end
         #1;
         waitc = 0;
         while (!f_rsp_valid && waitc < 20) begin
            @(negedge clk); #1; waitc++;
         end
         n_checks++;
         if (f_rsp_valid !== 1'b1 || f_rsp_c !== ec || f_rsp_id !== ((k == 4) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL fixed_rsp%0d: got v=%b c=%b id=%b expected v=1 c=%b id=%0d", k,
                     f_rsp_valid, f_rsp_c, f_rsp_id, ec, (k == 4) ? 1 : 0);
         end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (f_op_count !== 8'd5) begin
         n_fail++; $display("FAIL fixed_count: got %0d expected 5", f_op_count);
      end
   endtask

   task automatic test_neg_zero();
      logic gid, zero, rid, eg; logic [4:0] c; int lat; bit stable, ok;
      logic [2:0] ta [2]; logic [2:0] tb [2];
      ta[0] = 3'b100; tb[0] = 3'b100;
      ta[1] = 3'b010; tb[1] = 3'b110;
      for (int k = 0; k < 2; k++) begin
         eg = exp_grant(1'b1, 1'b0);
         run_op(1'b1, 1'b0, ta[k], tb[k], 1'b0, 3'b000, 3'b000, 1'b0, 0,
                gid, c, zero, rid, lat, stable, ok);
         ref_last = eg; exp_count++;
         n_checks++;
         if (!ok || c !== 5'b00000 || zero !== 1'b1) begin
            n_fail++; $display("FAIL neg_zero%0d: got %b/%b expected 00000/1", k, c, zero);
         end
      end
   endtask

   task automatic test_backpressure();
      logic gid, zero, rid, eg, eg2; logic [4:0] c, ec; int lat; bit stable, ok;
      logic [2:0] a0, b0, a1, b1; logic s0, s1;
      a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7)); s0 = 1'($urandom_range(0, 1));
      a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7)); s1 = 1'($urandom_range(0, 1));
      eg = exp_grant(1'b1, 1'b1);
      ec = eg ? ref_c(a1, b1, s1) : ref_c(a0, b0, s0);
      run_op(1'b1, 1'b1, a0, b0, s0, a1, b1, s1, 5, gid, c, zero, rid, lat, stable, ok);
      ref_last = eg; exp_count++;
      #1;
      n_checks++;
      if (!ok || !stable) begin
         n_fail++; $display("FAIL bp_stable: got ok=%0d stable=%0d expected 1/1", ok, stable);
      end
      n_checks++;
      if (c !== ec || rid !== eg) begin
         n_fail++; $display("FAIL bp_result: got %b/%b expected %b/%b", c, rid, ec, eg);
      end
      n_checks++;
      if (op_count !== 8'(exp_count)) begin
         n_fail++; $display("FAIL bp_count: got %0d expected %0d", op_count, exp_count);
      end
      // The other port has been pending throughout; drain it.
      eg2 = ~eg;
      ec = eg2 ? ref_c(a1, b1, s1) : ref_c(a0, b0, s0);
      run_op(~eg2, eg2, a0, b0, s0, a1, b1, s1, 0, gid, c, zero, rid, lat, stable, ok);
      ref_last = eg2; exp_count++;
      n_checks++;
      if (!ok || c !== ec || rid !== eg2) begin
         n_fail++; $display("FAIL bp_pending: got %b/%b expected %b/%b", c, rid, ec, eg2);
      end
   endtask

   task automatic test_reset_mid_op();
      int waitc; bit seen;
      rsp_ready = 1'b1;
      req0_a = 3'b011; req0_b = 3'b001; req0_s = 1'b0; req0_valid = 1'b1;
      #1;
      waitc = 0;
      while (!req0_ready && waitc < 20) begin
         @(negedge clk); #1; waitc++;
      end
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({rsp_valid, busy, rsp_c, rsp_id, rsp_zero} !== 9'b0 || op_count !== 8'd0) begin
         n_fail++;
         $display("FAIL midop_reset: got %b cnt=%0d expected 000000000 cnt=0",
                  {rsp_valid, busy, rsp_c, rsp_id, rsp_zero}, op_count);
      end
      @(negedge clk);
      rst = 1'b0;
      ref_last = 1'b1; exp_count = 0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (rsp_valid || busy) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL midop_no_rsp: got activity expected none"); end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      logic gid, zero, rid, eg, p; logic [4:0] c, ec; int lat; bit stable, ok;
      logic [2:0] a, b; logic s; int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) begin
         p = 1'($urandom_range(0, 1));
         a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7)); s = 1'($urandom_range(0, 1));
         eg = exp_grant(~p, p);
         ec = ref_c(a, b, s);
         run_op(~p, p, a, b, s, a, b, s, 0, gid, c, zero, rid, lat, stable, ok);
         ref_last = eg; exp_count++;
         #1;
         n_checks++;
         if (!ok || c !== ec || rid !== eg || zero !== (ec[3:0] == 4'd0) ||
             op_count !== 8'(exp_count)) begin
            n_fail++; bad++;
            if (bad < 5)
               $display("FAIL wrap_op%0d: got c=%b id=%b cnt=%0d expected c=%b id=%b cnt=%0d",
                        k, c, rid, op_count, ec, eg, exp_count % 256);
         end
      end
      n_checks++;
      if (op_count !== 8'd0) begin
         n_fail++; $display("FAIL wrap_count: got %0d expected 0", op_count);
      end
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b1; f_rsp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_s = 1'b0; req1_a = '0; req1_b = '0; req1_s = 1'b0;
      f_req0_a = '0; f_req0_b = '0; f_req0_s = 1'b0; f_req1_a = '0; f_req1_b = '0;
      f_req1_s = 1'b0;
      @(negedge clk);
      test_reset();
      test_port0();
      test_port1();
      test_round_robin();
      test_fixed_priority();
      test_neg_zero();
      test_backpressure();
      test_reset_mid_op();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/add_sub_arbiter.md
# add_sub_arbiter

Two-requester controller that shares the single combinational `add_sub` sign-magnitude datapath between two clients. It accepts one operation at a time over valid/ready handshakes, arbitrates round-robin or fixed-priority, registers the 5-bit result, and returns it tagged with the requester id. A wrap-around counter records completed operations. It sits between the calculator's input front-ends and the display/result path.

## Interface
- `ROUND_ROBIN`, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- `CNT_W`, default 8: width of the completed-operation counter.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req0_valid` input 1: port 0 has an operation.
- `req0_ready` output 1: port 0 operation accepted this cycle.
- `req0_a`, `req0_b` input 3 each: sign-magnitude operands; bit 2 = sign, bits 1:0 = magnitude.
- `req0_s` input 1: 0 = a+b, 1 = a−b.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_s`: same as port 0, for port 1.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts result.
- `rsp_c` output 5: sign-magnitude result; bit 4 = sign, bits 3:0 = magnitude (0..6).
- `rsp_id` output 1: requester that issued the result.
- `rsp_zero` output 1: result magnitude is 0.
- `busy` output 1: state ≠ IDLE.
- `op_count` output CNT_W: completed response handshakes, modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, compute the grant.
  - Assert the granted `reqN_ready` combinationally in this cycle only.
  - Capture a/b/s and the id into the operand registers, then go to EXEC.
  - If no request is valid, stay in IDLE.
- Grant rules:
  - Only one port valid: grant it.
  - Both valid, `ROUND_ROBIN`=1: grant the port not granted last; `last_grant` updates on each accept.
  - Both valid, `ROUND_ROBIN`=0: grant port 0.
- EXEC:
  - The `add_sub` instance is driven from the operand registers.
  - Its output `c` is registered into `rsp_c`, `rsp_zero` = (`c[3:0]`==0), `rsp_valid`←1, then go to RESP.
- Negative-zero normalization: if `c[3:0]`==0, `rsp_c` is forced to 5'b00000. For example, −0 + −0 gives 00000, not 10000.
- RESP:
  - Hold `rsp_c`, `rsp_id` and `rsp_zero` stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_valid && rsp_ready`: `rsp_valid`←0, `op_count`←`op_count`+1 (wraps from all-ones to 0), go to IDLE.
- No new request is accepted in EXEC or RESP; both `reqN_ready` are 0 there.
- Requesters must not make `valid` depend on `ready`; `ready` must not depend on `rsp_ready`.

## Timing
- Reset, asynchronous: state=IDLE, `rsp_valid`=0, `rsp_c`=0, `rsp_id`=0, `rsp_zero`=0, `op_count`=0, `last_grant`=1 (port 0 wins first), operand registers=0. `busy`=0 and both ready outputs are 0 while `rst` is high.
- Accept at edge N means `rsp_valid`=1 after edge N+1, i.e. 2 cycles from ready to valid.
- Minimum 3 cycles per operation, with an IDLE cycle between operations.
- Reset mid-operation: the in-flight operation is dropped and no response is produced.
- A valid request on a port that is not granted stays pending; the requester must hold its operands.
- `rsp_ready` held high in RESP: the handshake completes on the first RESP cycle.

## Structure
- Shared package `add_sub_pkg` contains:
  - FSM state localparams IDLE/EXEC/RESP.
  - Operand width 3, result width 5.
  - Port id constants PORT0=0 and PORT1=1.
- The only sub-module is the existing `add_sub` (ports a, b, s, c), instantiated once.
- Arbitration, FSM and counter are inline.

## Test plan
- Port 0 only: a=011, b=010, s=0 → `rsp_c`=00101, `rsp_id`=0, `rsp_zero`=0, `rsp_valid` 2 cycles after ready.
- Port 1 only: a=111, b=001, s=0 → `rsp_c`=10010. Then a=001, b=011, s=1 → `rsp_c`=10010.
- Both valid for 4 operations, `ROUND_ROBIN`=1 → grants 0,1,0,1. With `ROUND_ROBIN`=0 → grants 0,0,0,0 while port 1 stays pending.
- Negative zero: a=100, b=100, s=0 → `rsp_c`=00000, `rsp_zero`=1. Also a=010, b=110, s=0 → 00000.
- Backpressure: `rsp_ready`=0 for 5 cycles → result stable, both ready outputs 0, `op_count` unchanged; it increments by 1 on the handshake.
- Assert `rst` during EXEC → all outputs return to reset values immediately, no response. Then run 256 operations with `CNT_W`=8 → `op_count` wraps to 0.
